// File: rtl/panel_frame_scheduler.sv
// panel_frame_scheduler
//   Snapshots the virtual-board panel state (10 LEDs, six 7-segment digits),
//   wraps it in a 10-byte frame (header, LEDs, digits, XOR checksum) and
//   streams it byte by byte to the UART transmitter. A frame may start only
//   on a refresh tick, and only when the panel changed, nothing has been sent
//   since reset, or the keepalive interval has elapsed.
//
// Ports
//   i_CLK       system clock
//   i_RST       synchronous active-high reset (aborts any frame in flight)
//   i_LEDS      LED state to report
//   i_7S        7-segment state, [41:35]=HEX5 ... [6:0]=HEX0
//   o_TX_DATA   byte offered to the transmitter
//   o_TX_VALID  o_TX_DATA is valid
//   i_TX_READY  transmitter accepts the offered byte this cycle
//   o_BUSY      frame in progress (SEND or DONE)
//   o_SENT      one-cycle pulse after the last byte was accepted
//
// Handshake: a byte moves on every cycle where o_TX_VALID && i_TX_READY.
// Once raised, o_TX_VALID stays high and o_TX_DATA stays stable until that
// byte moves; the next byte (if any) is offered on the following cycle, so
// a continuously ready transmitter takes one byte per cycle.
module panel_frame_scheduler #(
    parameter int          CLOCK      = 50000000,
    parameter int          REFRESH_HZ = 100,
    parameter int          KEEPALIVE  = 100,
    parameter logic [7:0]  HEADER     = 8'hA5
) (
    input  logic        i_CLK,
    input  logic        i_RST,
    input  logic [9:0]  i_LEDS,
    input  logic [41:0] i_7S,
    output logic [7:0]  o_TX_DATA,
    output logic        o_TX_VALID,
    input  logic        i_TX_READY,
    output logic        o_BUSY,
    output logic        o_SENT
);

    localparam int DIV_RAW = CLOCK / REFRESH_HZ;
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int KW      = (KEEPALIVE > 0) ? $clog2(KEEPALIVE + 1) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [KW-1:0] KA_MAX    = KW'(KEEPALIVE);
    localparam logic [KW-1:0] KA_FIRE   = KW'(KEEPALIVE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [TW-1:0]   r_tick_cnt;
    logic [KW-1:0]   r_ka_cnt;
    logic            r_never_sent;
    // Frame snapshot; it doubles as the last-sent reference for change
    // detection because every started frame is also the one sent.
    logic [51:0]     r_snap;
    logic [3:0]      r_idx;
    logic [7:0]      r_tx_data;
    logic            r_tx_valid;
    logic            r_busy;
    logic            r_sent;

    logic            w_tick;
    logic [51:0]     w_panel;
    logic            w_start;
    logic [7:0]      w_cksum;
    logic [3:0]      w_next_idx;
    logic [7:0]      w_next_byte;

    assign w_tick  = (r_tick_cnt == TICK_LAST);
    assign w_panel = {i_LEDS, i_7S};
    // r_ka_cnt is compared before this tick's increment lands.
    assign w_start = w_tick && (r_never_sent || (w_panel != r_snap) || (r_ka_cnt == KA_FIRE));

    assign w_cksum = HEADER
                   ^ {6'b0, r_snap[51:50]}
                   ^ r_snap[49:42]
                   ^ {1'b0, r_snap[41:35]}
                   ^ {1'b0, r_snap[34:28]}
                   ^ {1'b0, r_snap[27:21]}
                   ^ {1'b0, r_snap[20:14]}
                   ^ {1'b0, r_snap[13:7]}
                   ^ {1'b0, r_snap[6:0]};

    assign w_next_idx = r_idx + 4'd1;

    always_comb begin
        w_next_byte = 8'h00;
        case (w_next_idx)
            4'd0:    w_next_byte = HEADER;
            4'd1:    w_next_byte = {6'b0, r_snap[51:50]};
            4'd2:    w_next_byte = r_snap[49:42];
            4'd3:    w_next_byte = {1'b0, r_snap[41:35]};
            4'd4:    w_next_byte = {1'b0, r_snap[34:28]};
            4'd5:    w_next_byte = {1'b0, r_snap[27:21]};
            4'd6:    w_next_byte = {1'b0, r_snap[20:14]};
            4'd7:    w_next_byte = {1'b0, r_snap[13:7]};
            4'd8:    w_next_byte = {1'b0, r_snap[6:0]};
            4'd9:    w_next_byte = w_cksum;
            default: w_next_byte = 8'h00;
        endcase
    end

    // Free-running refresh tick, independent of the frame state.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_state      <= S_IDLE;
            r_ka_cnt     <= '0;
            r_never_sent <= 1'b1;
            r_snap       <= '0;
            r_idx        <= '0;
            r_tx_data    <= '0;
            r_tx_valid   <= 1'b0;
            r_busy       <= 1'b0;
            r_sent       <= 1'b0;
        end else begin
            if (w_tick && (r_ka_cnt != KA_MAX)) begin
                r_ka_cnt <= r_ka_cnt + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    r_sent <= 1'b0;
                    // Ticks arriving in SEND/DONE are dropped, not remembered.
                    if (w_start) begin
                        r_snap       <= w_panel;
                        r_never_sent <= 1'b0;
                        r_ka_cnt     <= '0;
                        r_idx        <= '0;
                        r_tx_data    <= HEADER;
                        r_tx_valid   <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (r_tx_valid && i_TX_READY) begin
                        if (r_idx == 4'd9) begin
                            r_tx_valid <= 1'b0;
                            r_sent     <= 1'b1;
                            r_state    <= S_DONE;
                        end else begin
                            r_idx     <= w_next_idx;
                            r_tx_data <= w_next_byte;
                        end
                    end
                end
                S_DONE: begin
                    r_sent  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_TX_DATA  = r_tx_data;
    assign o_TX_VALID = r_tx_valid;
    assign o_BUSY     = r_busy;
    assign o_SENT     = r_sent;

endmodule

// File: tb/tb_panel_frame_scheduler.sv
// tb_panel_frame_scheduler
//   Bench for panel_frame_scheduler with CLOCK=1000, REFRESH_HZ=100 (tick every
//   10 cycles, on cycle index 9, 19, 29, ... counted from reset release) and
//   KEEPALIVE=3. Expected frames are queued when the panel inputs are driven;
//   a monitor pops and compares one byte per accepted transfer.
module tb_panel_frame_scheduler;

    logic        clk;
    logic        rst;
    logic [9:0]  leds;
    logic [41:0] seg;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        sent;

    int checks;
    int failures;
    int cyc;
    int xfer_cnt;
    logic [7:0] exp_q[$];

    panel_frame_scheduler #(
        .CLOCK      (1000),
        .REFRESH_HZ (100),
        .KEEPALIVE  (3),
        .HEADER     (8'hA5)
    ) dut (
        .i_CLK      (clk),
        .i_RST      (rst),
        .i_LEDS     (leds),
        .i_7S       (seg),
        .o_TX_DATA  (tx_data),
        .o_TX_VALID (tx_valid),
        .i_TX_READY (tx_ready),
        .o_BUSY     (busy),
        .o_SENT     (sent)
    );

    // Clock and cycle index (0 = first cycle after reset released).
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Scoreboard: every accepted byte must be the next queued expected byte.
    always @(negedge clk) begin
        if (!rst && tx_valid && tx_ready) begin
            logic [7:0] exp_b;
            xfer_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_byte cyc=%0d got=%h expected=none", cyc, tx_data);
            end else begin
                exp_b = exp_q.pop_front();
                if (tx_data !== exp_b) begin
                    failures++;
                    $display("FAIL frame_byte cyc=%0d got=%h expected=%h", cyc, tx_data, exp_b);
                end
            end
        end
    end

    task automatic push_frame(input logic [9:0] l, input logic [41:0] s);
        logic [7:0] b[10];
        logic [7:0] x;
        b[0] = 8'hA5;
        b[1] = {6'b0, l[9:8]};
        b[2] = l[7:0];
        for (int i = 0; i < 6; i++) b[3+i] = {1'b0, s[41-7*i -: 7]};
        x = 8'h00;
        for (int i = 0; i < 9; i++) x = x ^ b[i];
        b[9] = x;
        for (int i = 0; i < 10; i++) exp_q.push_back(b[i]);
    endtask

    // Advance to just after the posedge that starts cycle k (bounded).
    task automatic goto(input int k);
        int n;
        n = 0;
        while (cyc != k && n < 400) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (cyc != k) begin
            failures++;
            $display("FAIL goto_cycle got=%0d expected=%0d", cyc, k);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        leds = 10'h2A5;
        seg = {6{7'h7F}};
        tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        @(negedge clk);
        checks++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 || sent !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got=v%b d%h b%b s%b expected=v0 d00 b0 s0", tx_valid, tx_data, busy, sent);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic test_first_frame();
        push_frame(leds, seg);
        goto(9);  @(negedge clk);
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL first_pre_tick got=v%b b%b expected=v0 b0", tx_valid, busy);
        end
        goto(10); @(negedge clk);
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hA5 || busy !== 1'b1) begin
            failures++;
            $display("FAIL first_start got=v%b d%h b%b expected=v1 dA5 b1", tx_valid, tx_data, busy);
        end
        // A5 ^ 02 ^ A5 = 02, and six equal 7F bytes cancel out.
        goto(19); @(negedge clk);
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h02) begin
            failures++;
            $display("FAIL first_checksum got=v%b d%h expected=v1 d02", tx_valid, tx_data);
        end
        goto(20); @(negedge clk);
        checks++;
        if (sent !== 1'b1 || tx_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL first_sent got=s%b v%b b%b expected=s1 v0 b1", sent, tx_valid, busy);
        end
        goto(21); @(negedge clk);
        checks++;
        if (sent !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL first_sent_width got=s%b b%b expected=s0 b0", sent, busy);
        end
    endtask

    task automatic test_keepalive();
        int high;
        high = 0;
        push_frame(leds, seg);
        for (int k = 22; k < 40; k++) begin
            goto(k); @(negedge clk);
            if (tx_valid !== 1'b0) high++;
        end
        checks++;
        if (high != 0) begin
            failures++;
            $display("FAIL keepalive_gap got=%0d valid_cycles expected=0", high);
        end
        goto(40); @(negedge clk);
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
            failures++;
            $display("FAIL keepalive_start got=v%b d%h expected=v1 dA5", tx_valid, tx_data);
        end
        goto(50); @(negedge clk);
        checks++;
        if (sent !== 1'b1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL keepalive_done got=s%b left=%0d expected=s1 left=0", sent, exp_q.size());
        end
    endtask

    task automatic test_change();
        goto(55);
        leds = 10'h2A4;
        push_frame(leds, seg);
        goto(60); @(negedge clk);
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
            failures++;
            $display("FAIL change_start got=v%b d%h expected=v1 dA5", tx_valid, tx_data);
        end
        // Change during the frame: must only show up in the following frame.
        goto(63);
        leds = 10'h2A5;
        push_frame(leds, seg);
        goto(70); @(negedge clk);
        checks++;
        if (sent !== 1'b1) begin
            failures++;
            $display("FAIL change_sent got=%b expected=1", sent);
        end
        goto(79); @(negedge clk);
        checks++;
        if (tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL change_gap got=%b expected=0", tx_valid);
        end
        goto(80); @(negedge clk);
        checks++;
        if (tx_valid !== 1'b1) begin
            failures++;
            $display("FAIL change_next_start got=%b expected=1", tx_valid);
        end
        goto(90); @(negedge clk);
        checks++;
        if (sent !== 1'b1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL change_done got=s%b left=%0d expected=s1 left=0", sent, exp_q.size());
        end
    endtask

    task automatic test_stall();
        int x0;
        int bad;
        bad = 0;
        goto(91);
        x0 = xfer_cnt;
        seg[34:28] = 7'h3C;
        push_frame(leds, seg);
        // b0..b3 go on cycles 100..103; b4 is held through cycles 104..108.
        for (int k = 104; k < 109; k++) begin
            goto(k);
            if (k == 104) tx_ready = 1'b0;
            @(negedge clk);
            if (tx_valid !== 1'b1 || tx_data !== 8'h3C) begin
                bad++;
                $display("FAIL stall_hold cyc=%0d got=v%b d%h expected=v1 d3C", k, tx_valid, tx_data);
            end
        end
        checks++;
        if (bad != 0) failures++;
        goto(109);
        tx_ready = 1'b1;
        goto(115); @(negedge clk);
        checks++;
        if (sent !== 1'b1) begin
            failures++;
            $display("FAIL stall_sent got=%b expected=1", sent);
        end
        checks++;
        if (xfer_cnt - x0 != 10 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL stall_count got=%0d left=%0d expected=10 left=0", xfer_cnt - x0, exp_q.size());
        end
    endtask

    task automatic test_ready_toggle();
        int high;
        high = 0;
        goto(116);
        seg[41:35] = 7'h11;
        push_frame(leds, seg);
        // Transfers on 120,122,124,126,128..133; the tick at 129 falls mid-frame.
        for (int k = 120; k < 128; k++) begin
            goto(k);
            tx_ready = (k % 2 == 0);
            if (k == 125) begin
                seg[13:7] = 7'h22;
                push_frame(leds, seg);
            end
        end
        goto(128);
        tx_ready = 1'b1;
        goto(129); @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL toggle_busy_at_tick got=%b expected=1", busy);
        end
        goto(134); @(negedge clk);
        checks++;
        if (sent !== 1'b1) begin
            failures++;
            $display("FAIL toggle_sent got=%b expected=1", sent);
        end
        for (int k = 135; k < 140; k++) begin
            goto(k); @(negedge clk);
            if (tx_valid !== 1'b0) high++;
        end
        checks++;
        if (high != 0) begin
            failures++;
            $display("FAIL toggle_tick_queued got=%0d valid_cycles expected=0", high);
        end
        goto(140); @(negedge clk);
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
            failures++;
            $display("FAIL toggle_next_start got=v%b d%h expected=v1 dA5", tx_valid, tx_data);
        end
        goto(150); @(negedge clk);
        checks++;
        if (sent !== 1'b1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL toggle_done got=s%b left=%0d expected=s1 left=0", sent, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        goto(151);
        leds = 10'h3FF;
        push_frame(leds, seg);
        goto(165);
        rst = 1'b1;
        goto(0);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || sent !== 1'b0) begin
            failures++;
            $display("FAIL reset_abort got=v%b b%b s%b expected=v0 b0 s0", tx_valid, busy, sent);
        end
        exp_q.delete();
        // Inputs equal the aborted snapshot, yet never-sent forces a frame.
        push_frame(leds, seg);
        goto(9); @(negedge clk);
        checks++;
        if (tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_pre_tick got=%b expected=0", tx_valid);
        end
        goto(10); @(negedge clk);
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
            failures++;
            $display("FAIL reset_restart got=v%b d%h expected=v1 dA5", tx_valid, tx_data);
        end
        goto(20); @(negedge clk);
        checks++;
        if (sent !== 1'b1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL reset_full_frame got=s%b left=%0d expected=s1 left=0", sent, exp_q.size());
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        xfer_cnt = 0;
        test_reset();
        test_first_frame();
        test_keepalive();
        test_change();
        test_stall();
        test_ready_toggle();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
